reg_sw: RTL and testbench



---
 rtl/reg_sw_pkg.sv | 10 +
 rtl/reg_sw.sv | 28 ++
 tb/tb_reg_sw.sv | 110 +++++++++++
 3 files changed

// File: rtl/reg_sw_pkg.sv
// Sim-AC common definitions: status-word width and flag bit positions.
package reg_sw_pkg;

  localparam int unsigned SW_WIDTH = 2;

  // Flag bit positions shared by the ALU flag logic and the control unit.
  localparam int unsigned SW_ZERO_BIT = 0;
  localparam int unsigned SW_NEG_BIT  = 1;

endpackage

// File: rtl/reg_sw.sv
// Status-word register: holds condition flags between instructions.
module reg_sw
  import reg_sw_pkg::*;
#(
  parameter int unsigned      WIDTH       = SW_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sw_q;

  // Reset has priority over a write; otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_q <= RESET_VALUE;
    end else if (wen_i) begin
      sw_q <= d_i;
    end
  end

  assign q_o = sw_q;

endmodule

// File: tb/tb_reg_sw.sv
// Self-checking bench for reg_sw: directed sequence plus randomized traffic.
module tb_reg_sw;

  localparam int unsigned W2 = 4;
  localparam logic [W2-1:0] RV2 = 4'hA;

  logic          clk;
  logic          rst;
  logic          wen;
  logic [1:0]    d;
  logic [1:0]    q;
  logic [W2-1:0] d2;
  logic [W2-1:0] q2;

  int checks = 0;
  int errors = 0;

  logic [1:0]    exp_q;
  logic [W2-1:0] exp_q2;

  reg_sw dut (
    .clk_i(clk),
    .rst_i(rst),
    .wen_i(wen),
    .d_i  (d),
    .q_o  (q)
  );

  reg_sw #(.WIDTH(W2), .RESET_VALUE(RV2)) dut_w4 (
    .clk_i(clk),
    .rst_i(rst),
    .wen_i(wen),
    .d_i  (d2),
    .q_o  (q2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, clock one edge, update the reference, and check both instances.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [1:0] dv, input logic [W2-1:0] dv2);
    rst = r;
    wen = w;
    d   = dv;
    d2  = dv2;
    @(posedge clk);
    if (r) begin
      exp_q  = 2'b00;
      exp_q2 = RV2;
    end else if (w) begin
      exp_q  = dv;
      exp_q2 = dv2;
    end
    #1;
    check(tag, 32'(q), 32'(exp_q));
    check({tag, "_w4"}, 32'(q2), 32'(exp_q2));
  endtask

  initial begin
    logic [1:0] seq [4];
    rst = 1'b0;
    wen = 1'b0;
    d   = '0;
    d2  = '0;
    exp_q  = 'x;
    exp_q2 = 'x;
    @(negedge clk);

    step("reset", 1'b1, 1'b0, 2'b11, 4'h5);
    step("reset_hold", 1'b1, 1'b0, 2'b10, 4'h3);
    step("write11", 1'b0, 1'b1, 2'b11, 4'hC);
    step("hold01", 1'b0, 1'b0, 2'b01, 4'h1);
    for (int i = 0; i < 4; i++) begin
      step("hold_toggle", 1'b0, 1'b0, 2'(i), 4'(i * 3));
    end
    check("hold_final", 32'(q), 32'(2'b11));
    step("rewrite01", 1'b0, 1'b1, 2'b01, 4'h6);
    step("rst_prio", 1'b1, 1'b1, 2'b10, 4'hF);
    check("rst_prio_abs", 32'(q), 32'(2'b00));
    step("rst_release", 1'b0, 1'b1, 2'b10, 4'h9);
    check("rst_release_abs", 32'(q), 32'(2'b10));

    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step("stream", 1'b0, 1'b1, seq[i], 4'(15 - i));
      check("stream_abs", 32'(q), 32'(seq[i]));
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step("random", ($urandom_range(0, 19) == 0), 1'($urandom),
           2'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
